csa_pipe_adder: RTL and testbench

Parametrised, two-stage pipelined carry-select adder/subtractor with valid/ready handshakes on input and output. Operands are split into BLOCK-bit groups. Stage 1 precomputes each group's sum and carry for carry-in 0 and carry-in 1. Stage 2 resolves the group carry chain through select muxes and registers the result with carry, signed-overflow and zero flags; it is the datapath adder for wider arithmetic units.

---
 rtl/csa_pipe_adder.sv | 122 ++++++++++++
 tb/tb_csa_pipe_adder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_pipe_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready handshakes.
// Stage 1 precomputes per-group sums for both carry-ins; stage 2 resolves the select chain.

module csa_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] bb,
  input  logic             cin_lo,
  output logic [BLOCK-1:0] s0,
  output logic [BLOCK-1:0] s1,
  output logic             c0,
  output logic             c1
);
  // cin_lo carries the real carry-in for group 0 and is tied to 0 elsewhere
  assign {c0, s0} = {1'b0, a} + {1'b0, bb} + {{BLOCK{1'b0}}, cin_lo};
  assign {c1, s1} = {1'b0, a} + {1'b0, bb} + {{BLOCK{1'b0}}, 1'b1};
endmodule

module csa_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NG = WIDTH / BLOCK;

  logic [WIDTH-1:0]           bb;
  logic                       ce;
  logic [NG-1:0][BLOCK-1:0]   s0_d, s1_d, s0_q, s1_q;
  logic [NG-1:0]              c0_d, c1_d, c0_q, c1_q;
  logic                       a_msb_q, bb_msb_q;
  logic [2:1]                 vld_pipe;
  logic                       ld1, ld2;
  logic [NG:0]                cy;
  logic [NG-1:0][BLOCK-1:0]   res;
  logic [WIDTH-1:0]           sum_d;
  logic                       ovf_d;

  assign bb = b ^ {WIDTH{sub}};
  assign ce = cin ^ sub;

  assign ld2       = !vld_pipe[2] || out_ready;
  assign ld1       = !vld_pipe[1] || ld2;
  assign in_ready  = ld1;
  assign out_valid = vld_pipe[2];

  for (genvar g = 0; g < NG; g++) begin : g_grp
    csa_group #(.BLOCK(BLOCK)) u_grp (
      .a      (a[g*BLOCK +: BLOCK]),
      .bb     (bb[g*BLOCK +: BLOCK]),
      .cin_lo ((g == 0) ? ce : 1'b0),
      .s0     (s0_d[g]),
      .s1     (s1_d[g]),
      .c0     (c0_d[g]),
      .c1     (c1_d[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      s0_q        <= '0;
      s1_q        <= '0;
      c0_q        <= '0;
      c1_q        <= '0;
      a_msb_q     <= 1'b0;
      bb_msb_q    <= 1'b0;
    end else if (ld1) begin
      vld_pipe[1] <= in_valid;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      c0_q        <= c0_d;
      c1_q        <= c1_d;
      a_msb_q     <= a[WIDTH-1];
      bb_msb_q    <= bb[WIDTH-1];
    end
  end

  // Group 0 already absorbed the carry-in, so the chain starts from 0
  always_comb begin
    cy    = '0;
    res   = '0;
    cy[0] = 1'b0;
    for (int g = 0; g < NG; g++) begin
      res[g]  = cy[g] ? s1_q[g] : s0_q[g];
      cy[g+1] = cy[g] ? c1_q[g] : c0_q[g];
    end
  end

  assign sum_d = res;
  assign ovf_d = (a_msb_q == bb_msb_q) && (sum_d[WIDTH-1] != a_msb_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[2] <= 1'b0;
      sum         <= '0;
      cout        <= 1'b0;
      ovf         <= 1'b0;
      zero        <= 1'b0;
    end else if (ld2) begin
      vld_pipe[2] <= vld_pipe[1];
      sum         <= sum_d;
      cout        <= cy[NG];
      ovf         <= ovf_d;
      zero        <= ~|sum_d;
    end
  end
endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder: directed 16/4 checks plus a scoreboarded random stream
// run in lockstep on 16/4, 8/2, 32/8 and 12/12 instances.
module tb_csa_pipe_adder;
  logic        clk, rst_n;
  logic        in_valid, out_ready, cin_in, sub_in;
  logic [31:0] a_in, b_in;
  logic [3:0]  in_ready, out_valid, cout, ovf, zero;
  logic [15:0] s16;
  logic [7:0]  s8;
  logic [31:0] s32;
  logic [11:0] s12;
  logic [31:0] sum_x [4];

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
  } beat_t;

  beat_t sbq [4][$];
  int    wid [4] = '{16, 8, 32, 12};
  int    n_assert = 0, n_fail = 0, drained = 0;

  assign sum_x[0] = {16'd0, s16};
  assign sum_x[1] = {24'd0, s8};
  assign sum_x[2] = s32;
  assign sum_x[3] = {20'd0, s12};

  csa_pipe_adder #(.WIDTH(16), .BLOCK(4)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(out_valid[0]), .out_ready(out_ready), .sum(s16),
    .cout(cout[0]), .ovf(ovf[0]), .zero(zero[0]));
  csa_pipe_adder #(.WIDTH(8), .BLOCK(2)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(out_valid[1]), .out_ready(out_ready), .sum(s8),
    .cout(cout[1]), .ovf(ovf[1]), .zero(zero[1]));
  csa_pipe_adder #(.WIDTH(32), .BLOCK(8)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
    .out_valid(out_valid[2]), .out_ready(out_ready), .sum(s32),
    .cout(cout[2]), .ovf(ovf[2]), .zero(zero[2]));
  csa_pipe_adder #(.WIDTH(12), .BLOCK(12)) u_d12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[3]),
    .a(a_in[11:0]), .b(b_in[11:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(out_valid[3]), .out_ready(out_ready), .sum(s12),
    .cout(cout[3]), .ovf(ovf[3]), .zero(zero[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands; returns {cout, ovf, zero, sum}
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub, input int w);
    longint unsigned m, aa, bv, full, s;
    logic c, o, z;
    m    = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & m;
    bv   = {32'd0, (sub ? ~b : b)} & m;
    full = aa + bv + {63'd0, cin ^ sub};
    s    = full & m;
    c    = full[w];
    o    = (aa[w-1] == bv[w-1]) && (s[w-1] != aa[w-1]);
    z    = (s == 0);
    return {c, o, z, s[31:0]};
  endfunction

  // One negedge observation: occupancy-based in_ready, then output/input transfers
  task automatic step();
    beat_t bt;
    logic [34:0] e;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("in_ready[%0d]", k), 32'(in_ready[k]),
            32'(out_ready || (sbq[k].size() < 2)));
      if (out_valid[k] && out_ready) begin
        if (sbq[k].size() == 0)
          check($sformatf("spurious_out[%0d]", k), 32'(sbq[k].size()), 32'd1);
        else begin
          bt = sbq[k].pop_front();
          e  = model(bt.a, bt.b, bt.cin, bt.sub, wid[k]);
          check($sformatf("sum[%0d]", k),  sum_x[k],      e[31:0]);
          check($sformatf("cout[%0d]", k), 32'(cout[k]),  32'(e[34]));
          check($sformatf("ovf[%0d]", k),  32'(ovf[k]),   32'(e[33]));
          check($sformatf("zero[%0d]", k), 32'(zero[k]),  32'(e[32]));
          if (k == 0) drained++;
        end
      end
      if (in_valid && in_ready[k]) begin
        bt.a = a_in; bt.b = b_in; bt.cin = cin_in; bt.sub = sub_in;
        sbq[k].push_back(bt);
      end
    end
  endtask

  // Single beat on the 16/4 instance: out_valid rises after the second edge
  // following the cycle in which the beat is presented and accepted.
  task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input logic [15:0] es,
                        input logic ec, input logic eo, input logic ez);
    @(posedge clk); #1;
    in_valid = 1'b1; a_in = {16'd0, a}; b_in = {16'd0, b}; cin_in = cin; sub_in = sub;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_early_valid"}, 32'(out_valid[0]), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(out_valid[0]), 32'd1);
    check({tag, "_sum"},   sum_x[0],          {16'd0, es});
    check({tag, "_cout"},  32'(cout[0]),      32'(ec));
    check({tag, "_ovf"},   32'(ovf[0]),       32'(eo));
    check({tag, "_zero"},  32'(zero[0]),      32'(ez));
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) sbq[k].delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] held;
    int idx;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_sum",       sum_x[0],          32'd0);
    check("rst_cout",      32'(cout[0]),      32'd0);
    check("rst_ovf",       32'(ovf[0]),       32'd0);
    check("rst_zero",      32'(zero[0]),      32'd0);
    check("rst_in_ready",  32'(in_ready[0]),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    single("add",      16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
    single("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    single("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    single("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    single("sub_neg",  16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    single("sub_brw",  16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    // Reset with two beats in flight and the output stalled
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b0; a_in = 32'h1111; b_in = 32'h2222;
    cin_in = 1'b0; sub_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full_valid",    32'(out_valid[0]), 32'd1);
    check("full_in_ready", 32'(in_ready[0]),  32'd0);
    check("full_sum",      sum_x[0],          32'h3333);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",    32'(out_valid[0]), 32'd0);
    check("arst_sum",      sum_x[0],          32'd0);
    check("arst_in_ready", 32'(in_ready[0]),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    single("post_rst", 16'hA5A5, 16'h1234, 1'b1, 1'b0, 16'hB7DA, 1'b0, 1'b0, 1'b0);

    // Backpressure: 5 back-to-back beats, 3 stalled cycles once the first result shows
    do_reset();
    idx = 0; held = '0; drained = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      in_valid  = (idx < 5);
      a_in      = 32'h1111 * (idx + 1);
      b_in      = 32'h0F0F + idx;
      cin_in    = 1'b0;
      sub_in    = idx[0];
      out_ready = !(c >= 2 && c <= 4);
      @(negedge clk);
      if (c == 2) held = sum_x[0];
      if (c >= 2 && c <= 4) begin
        check("bp_valid",    32'(out_valid[0]), 32'd1);
        check("bp_hold_sum", sum_x[0],          held);
        check("bp_in_ready", 32'(in_ready[0]),  32'd0);
      end
      if (in_valid && in_ready[0]) idx++;
      step();
    end
    check("bp_drained", 32'(drained), 32'd5);

    // Random stream on all four widths
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(3) != 0);
      a_in      = $urandom;
      b_in      = $urandom;
      cin_in    = $urandom_range(1) == 1;
      sub_in    = $urandom_range(1) == 1;
      if (c % 50 == 7) begin
        a_in = 32'hFFFF_FFFF; b_in = 32'd0; cin_in = 1'b1; sub_in = 1'b0;
      end
      out_ready = ($urandom_range(2) != 0);
      @(negedge clk);
      step();
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      step();
    end
    for (int k = 0; k < 4; k++)
      check($sformatf("left_in_flight[%0d]", k), 32'(sbq[k].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
